// File: rtl/clm_digit_serial_multiplier_pkg.sv
// Shared types and constants for the CLM multiplier family.
// Module parameters default to CLM_M/CLM_D; the typedefs below match those defaults.
package clm_digit_serial_multiplier_pkg;

  localparam int unsigned CLM_M  = 8;
  localparam int unsigned CLM_D  = 4;
  localparam int unsigned CLM_N  = CLM_M + CLM_D;
  localparam int unsigned CLM_PW = 2 * CLM_N - 1;
  localparam int unsigned CLM_OW = CLM_N - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_REDUCE,
    ST_DONE
  } state_t;

  typedef logic [CLM_D-1:0]                      red_poly_t;
  typedef logic [CLM_D+CLM_OW-1:0][CLM_M-1:0]    nm_matrix_t;

endpackage

// File: rtl/clm_systematic_encoder.sv
// Combinational systematic encoder: red = {r, B_ext^T * {ovf, r}}.
// Reusable by any CLM block that reduces through B_ext.
module clm_systematic_encoder #(
  parameter int unsigned M = 8,
  parameter int unsigned D = 4
) (
  input  logic [M+D-2:0]                 ovf,
  input  logic [D-1:0]                   r,
  input  logic [D+(M+D-1)-1:0][M-1:0]    b_ext,
  output logic [M+D-1:0]                 red
);

  localparam int unsigned OW = M + D - 1;
  localparam int unsigned R  = D + OW;

  logic [R-1:0]          sys;
  logic [M-1:0][R-1:0]   col;

  assign sys = {ovf, r};

  for (genvar i = 0; i < M; i++) begin : g_col
    for (genvar j = 0; j < R; j++) begin : g_row
      assign col[i][j] = b_ext[j][i];
    end
    assign red[i] = ^(sys & col[i]);
  end

  assign red[M+D-1:M] = r;

endmodule

// File: rtl/clm_digit_serial_multiplier.sv
// Digit-serial carry-less multiplier: DIGIT bits of p2 per ACC cycle, then one
// REDUCE cycle folding the overflow through the systematic encoder.
module clm_digit_serial_multiplier
  import clm_digit_serial_multiplier_pkg::*;
#(
  parameter int unsigned M     = CLM_M,
  parameter int unsigned D     = CLM_D,
  parameter int unsigned DIGIT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [M+D-1:0]                 p1,
  input  logic [M+D-1:0]                 p2,
  input  logic [D-1:0]                   r,
  input  logic [D+(M+D-1)-1:0][M-1:0]    b_ext,
  input  logic                           abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M+D-1:0]                 out,
  output logic                           busy
);

  localparam int unsigned N    = M + D;
  localparam int unsigned PW   = 2 * N - 1;
  localparam int unsigned OW   = N - 1;
  localparam int unsigned R    = D + OW;
  localparam int unsigned KMAX = N / DIGIT;
  localparam int unsigned KW   = (KMAX > 1) ? $clog2(KMAX) : 1;

  if ((D < 1) || (DIGIT < 1) || ((N % DIGIT) != 0)) begin : g_param_check
    $error("clm_digit_serial_multiplier: need D >= 1 and DIGIT dividing M+D");
  end

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [N-1:0]        p1_q, p2_q;
  logic [D-1:0]        r_q;
  logic [R-1:0][M-1:0] b_q;
  logic [PW-1:0]       acc_q, acc_d;
  logic [N-1:0]        out_q;
  logic                load, out_load;
  logic [N-1:0]        red;
  logic [31:0]         base;
  logic [PW-1:0]       p1_ext;
  logic [DIGIT:0][PW-1:0] pp;

  // Digit partial products are chained so the XOR fold is pure wiring per t.
  assign base   = 32'(k_q) * DIGIT;
  assign p1_ext = {{(PW-N){1'b0}}, p1_q};
  assign pp[0]  = '0;

  for (genvar t = 0; t < DIGIT; t++) begin : g_digit
    logic [31:0]  idx;
    logic [N-1:0] p2_sh;
    assign idx       = base + 32'(t);
    assign p2_sh     = p2_q >> idx;
    assign pp[t+1]   = pp[t] ^ (p2_sh[0] ? (p1_ext << idx) : '0);
  end

  clm_systematic_encoder #(.M(M), .D(D)) u_enc (
    .ovf   (acc_q[PW-1:N]),
    .r     (r_q),
    .b_ext (b_q),
    .red   (red)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    load     = 1'b0;
    out_load = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            acc_d   = '0;
            k_d     = '0;
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          acc_d = acc_q ^ pp[DIGIT];
          if (k_q == KW'(KMAX - 1)) state_d = ST_REDUCE;
          else                      k_d     = k_q + 1'b1;
        end
        ST_REDUCE: begin
          out_load = 1'b1;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      r_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
      if (load) begin
        p1_q <= p1;
        p2_q <= p2;
        r_q  <= r;
        b_q  <= b_ext;
      end
      if (out_load) out_q <= acc_q[N-1:0] ^ red;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;

endmodule

// File: tb/tb_clm_digit_serial_multiplier.sv
// Bench for clm_digit_serial_multiplier: three digit widths against a
// polynomial-arithmetic reference, plus directed handshake/abort/reset steps.
module tb_clm_digit_serial_multiplier;

  localparam int unsigned M  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned N  = M + D;
  localparam int unsigned OW = N - 1;
  localparam int unsigned PW = 2 * N - 1;
  localparam int unsigned R  = D + OW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                abort = 1'b0;
  logic                out_ready = 1'b0;
  logic [N-1:0]        p1 = '0, p2 = '0;
  logic [D-1:0]        r = '0;
  logic [R-1:0][M-1:0] b_ext = '0;
  logic [2:0]          in_ready, out_valid, busy;
  logic [N-1:0]        out0, out1, out2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clm_digit_serial_multiplier #(.M(M), .D(D), .DIGIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .p1(p1), .p2(p2), .r(r), .b_ext(b_ext), .abort(abort),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out(out0), .busy(busy[0]));

  clm_digit_serial_multiplier #(.M(M), .D(D), .DIGIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .p1(p1), .p2(p2), .r(r), .b_ext(b_ext), .abort(abort),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out(out1), .busy(busy[1]));

  clm_digit_serial_multiplier #(.M(M), .D(D), .DIGIT(N)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .p1(p1), .p2(p2), .r(r), .b_ext(b_ext), .abort(abort),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out(out2), .busy(busy[2]));

  // Reference: schoolbook GF(2)[x] product, then the overflow/refresh vector
  // selects rows of B_ext to XOR into the low M bits.
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [D-1:0] rr, input logic [R-1:0][M-1:0] bm);
    logic [PW-1:0] prod;
    logic [R-1:0]  sel;
    logic [M-1:0]  low;
    prod = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) prod = prod ^ (PW'(a) << i);
    sel = {prod[PW-1:N], rr};
    low = '0;
    for (int j = 0; j < R; j++)
      if (sel[j]) low = low ^ bm[j];
    return prod[N-1:0] ^ {rr, low};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    p1 = N'($urandom);
    p2 = N'($urandom);
    r  = D'($urandom);
    for (int j = 0; j < R; j++) b_ext[j] = M'($urandom);
  endtask

  task automatic accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [N-1:0] dut_out(input int d);
    return (d == 0) ? out0 : (d == 1) ? out1 : out2;
  endfunction

  int unsigned    lat [3];
  string          vtag [3];
  string          otag [3];
  logic [N-1:0]   exp_out;
  logic [N-1:0]   held;
  logic [R-1:0][M-1:0] b_keep;
  int             seen;

  initial begin
    lat  = '{N + 1, N / 2 + 1, 2};
    vtag = '{"rand_valid_d1", "rand_valid_d2", "rand_valid_dN"};
    otag = '{"rand_out_d1", "rand_out_d2", "rand_out_dN"};

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'h7);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_out0", 32'(out0), 32'h0);
    rst_n = 1'b1;
    step();

    // Random golden model, exact latency at DIGIT = 1, 2, N
    out_ready = 1'b1;
    for (int v = 0; v < 2000; v++) begin
      rand_ops();
      exp_out = model(p1, p2, r, b_ext);
      accept();
      rand_ops();
      for (int unsigned c = 1; c <= N + 1; c++) begin
        step();
        for (int d = 0; d < 3; d++) begin
          check(vtag[d], 32'(out_valid[d]), 32'(c == lat[d]));
          if (c == lat[d]) check(otag[d], 32'(dut_out(d)), 32'(exp_out));
        end
      end
      step();
    end

    // Identity with backpressure
    out_ready = 1'b0;
    rand_ops();
    p1 = 12'h0A5;
    p2 = 12'h001;
    r  = '0;
    accept();
    for (int unsigned c = 1; c <= N; c++) step();
    check("id_valid_early", 32'(out_valid[0]), 32'h0);
    step();
    check("id_valid", 32'(out_valid[0]), 32'h1);
    check("id_out", 32'(out0), 32'h0A5);
    held = out0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", 32'(out_valid[0]), 32'h1);
      check("bp_out_stable", 32'(out0), 32'(held));
      check("bp_in_ready", 32'(in_ready[0]), 32'h0);
    end

    // Handshake with in_valid already high: accept comes one cycle later
    rand_ops();
    p1 = '0;
    p2 = '0;
    r  = 4'b1001;
    b_keep = b_ext;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    check("hs_in_ready", 32'(in_ready[0]), 32'h1);
    check("hs_busy", 32'(busy[0]), 32'h0);
    check("hs_out_kept", 32'(out0), 32'h0A5);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("hs_accepted", 32'(busy[0]), 32'h1);
    rand_ops();

    // Zero product: only r and rows 0/3 of B_ext contribute
    for (int unsigned c = 1; c <= N + 1; c++) step();
    check("zero_valid", 32'(out_valid[0]), 32'h1);
    check("zero_hi", 32'(out0[M+:D]), 32'h9);
    check("zero_lo", 32'(out0[M-1:0]), 32'(b_keep[0] ^ b_keep[3]));

    // Abort beats out_ready in DONE
    abort     = 1'b1;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done_valid", 32'(out_valid[0]), 32'h0);
    check("abort_done_idle", 32'(in_ready[0]), 32'h1);

    // Abort beats in_valid in IDLE
    abort    = 1'b1;
    in_valid = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_noaccept", 32'(busy), 32'h0);

    // Abort in ACC: no result may appear afterwards
    rand_ops();
    accept();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_acc_busy", 32'(busy[0]), 32'h0);
    check("abort_acc_valid", 32'(out_valid[0]), 32'h0);
    seen = 0;
    for (int unsigned c = 0; c < N + 2; c++) begin
      step();
      if (out_valid[0]) seen++;
    end
    check("abort_acc_spurious", 32'(seen), 32'h0);

    // Asynchronous reset at ACC k=2, then a clean operation
    rand_ops();
    accept();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready[0]), 32'h1);
    check("arst_valid", 32'(out_valid[0]), 32'h0);
    check("arst_busy", 32'(busy[0]), 32'h0);
    check("arst_out", 32'(out0), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    rand_ops();
    exp_out = model(p1, p2, r, b_ext);
    accept();
    rand_ops();
    for (int unsigned c = 1; c <= N + 1; c++) step();
    check("post_rst_valid", 32'(out_valid[0]), 32'h1);
    check("post_rst_out", 32'(out0), 32'(exp_out));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
